// File: rtl/sme_scan.sv
// Sequential string-matching engine: stores one string, then scans it one
// candidate position per cycle against a pattern using '^', '$', '.' and one '*'.
module sme_scan #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int IDX_W   = 5,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             isstring,
  input  logic             ispattern,
  output logic             busy,
  output logic             valid,
  output logic             match,
  output logic [IDX_W-1:0] match_index,
  output logic [CNT_W-1:0] match_count,
  output logic [2:0]       dbg_state
);
  // Handshake: no backpressure. Characters are accepted on any cycle isstring or
  // ispattern is high outside busy; valid is a one-cycle strobe, results hold until the next one.
  localparam int PW = $clog2(STR_MAX + PAT_MAX + 2);
  localparam int KW = $clog2(PAT_MAX + 1);
  localparam int PI = $clog2(PAT_MAX);

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_STR = 3'd1,
    LOAD_PAT = 3'd2,
    SCAN     = 3'd3,
    SCAN_A   = 3'd4,
    SCAN_B   = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t state, state_n;

  logic [7:0]       str [STR_MAX];
  logic [7:0]       pat [PAT_MAX];
  logic [PW-1:0]    len, cur;
  logic [KW-1:0]    plen, star_k;
  logic             has_star, found;
  logic [IDX_W-1:0] first_idx, a_pos;
  logic [CNT_W-1:0] hit_cnt;

  logic             str_start, str_wr, pat_start, pat_wr;
  logic [KW-1:0]    ev_lo, ev_hi;
  logic             ev_ok;
  logic [PW-1:0]    ev_pos;
  logic [7:0]       ev_c, ch_cur, ch_prev;

  logic             done_set, res_match;
  logic [IDX_W-1:0] res_idx;
  logic [CNT_W-1:0] res_cnt;

  assign dbg_state = state;
  assign busy = (state == SCAN) || (state == SCAN_A) || (state == SCAN_B) || (state == DONE);

  assign str_start = (state == IDLE) && isstring;
  assign str_wr    = str_start ||
                     ((state == LOAD_STR) && !ispattern && isstring && (len < PW'(STR_MAX)));
  assign pat_start = ((state == IDLE) && !isstring && ispattern) ||
                     ((state == LOAD_STR) && ispattern);
  assign pat_wr    = pat_start ||
                     ((state == LOAD_PAT) && ispattern && (plen < KW'(PAT_MAX)));

  // Element range under evaluation: whole pattern, the part before '*', or the part after it.
  always_comb begin
    ev_lo = '0;
    ev_hi = plen;
    if (state == SCAN_A) ev_hi = star_k;
    else if (state == SCAN_B) ev_lo = star_k + KW'(1);
  end

  // Walks the selected elements from position cur; ev_pos ends one past the last consumed char.
  always_comb begin
    ev_ok   = 1'b1;
    ev_pos  = cur;
    ev_c    = '0;
    ch_cur  = '0;
    ch_prev = '0;
    for (int k = 0; k < PAT_MAX; k++) begin
      ev_c    = pat[k];
      ch_cur  = (ev_pos < PW'(STR_MAX)) ? str[ev_pos[IDX_W-1:0]] : 8'h00;
      ch_prev = ((ev_pos != '0) && (ev_pos <= PW'(STR_MAX))) ?
                str[IDX_W'(ev_pos - PW'(1))] : 8'h00;
      if ((KW'(k) >= ev_lo) && (KW'(k) < ev_hi) && ev_ok) begin
        if (ev_c == CH_CARET) begin
          if ((ev_pos != '0) && (ch_prev != CH_SPACE)) ev_ok = 1'b0;
        end else if (ev_c == CH_DOLLAR) begin
          if ((ev_pos != len) && !((ev_pos < len) && (ch_cur == CH_SPACE))) ev_ok = 1'b0;
        end else if ((ev_pos < len) && ((ev_c == CH_DOT) || (ev_c == ch_cur))) begin
          ev_pos = ev_pos + PW'(1);
        end else begin
          ev_ok = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    done_set  = 1'b0;
    res_match = 1'b0;
    res_idx   = '0;
    res_cnt   = '0;
    case (state)
      IDLE: begin
        if (isstring)       state_n = LOAD_STR;
        else if (ispattern) state_n = LOAD_PAT;
      end
      LOAD_STR: if (ispattern) state_n = LOAD_PAT;
      LOAD_PAT: begin
        if (!ispattern) begin
          if (len == '0) begin
            state_n  = DONE;
            done_set = 1'b1;
          end else if (!has_star) state_n = SCAN;
          else if (star_k == '0)  state_n = SCAN_B;
          else                    state_n = SCAN_A;
        end
      end
      SCAN: begin
        if (cur == len - PW'(1)) begin
          state_n   = DONE;
          done_set  = 1'b1;
          res_match = found | ev_ok;
          res_idx   = found ? first_idx : (ev_ok ? cur[IDX_W-1:0] : '0);
          res_cnt   = (ev_ok && (hit_cnt != {CNT_W{1'b1}})) ? hit_cnt + CNT_W'(1) : hit_cnt;
        end
      end
      SCAN_A: begin
        if (ev_ok) state_n = SCAN_B;
        else if (cur == len - PW'(1)) begin
          state_n  = DONE;
          done_set = 1'b1;
        end
      end
      SCAN_B: begin
        if (ev_ok) begin
          state_n   = DONE;
          done_set  = 1'b1;
          res_match = 1'b1;
          res_idx   = a_pos;
          res_cnt   = CNT_W'(1);
        end else if (cur == len) begin
          state_n  = DONE;
          done_set = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Character storage carries no reset: len and plen gate every read.
  always_ff @(posedge clk) begin
    if (str_wr) str[str_start ? IDX_W'(0) : len[IDX_W-1:0]] <= chardata;
    if (pat_wr) pat[pat_start ? PI'(0) : plen[PI-1:0]] <= chardata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len       <= '0;
      plen      <= '0;
      star_k    <= '0;
      has_star  <= 1'b0;
      cur       <= '0;
      found     <= 1'b0;
      first_idx <= '0;
      a_pos     <= '0;
      hit_cnt   <= '0;
    end else begin
      if (str_start)   len <= PW'(1);
      else if (str_wr) len <= len + PW'(1);

      if (pat_start) begin
        plen     <= KW'(1);
        has_star <= (chardata == CH_STAR);
        star_k   <= '0;
      end else if (pat_wr) begin
        plen <= plen + KW'(1);
        if ((chardata == CH_STAR) && !has_star) begin
          has_star <= 1'b1;
          star_k   <= plen;
        end
      end

      case (state)
        LOAD_PAT: begin
          if (!ispattern) begin
            cur     <= '0;
            found   <= 1'b0;
            hit_cnt <= '0;
            a_pos   <= '0;
          end
        end
        SCAN: begin
          cur <= cur + PW'(1);
          if (ev_ok) begin
            if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + CNT_W'(1);
            if (!found) begin
              found     <= 1'b1;
              first_idx <= cur[IDX_W-1:0];
            end
          end
        end
        SCAN_A: begin
          if (ev_ok) begin
            a_pos <= cur[IDX_W-1:0];
            cur   <= ev_pos;
          end else begin
            cur <= cur + PW'(1);
          end
        end
        SCAN_B:  cur <= cur + PW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      match_count <= '0;
    end else begin
      valid <= done_set;
      if (done_set) begin
        match       <= res_match;
        match_index <= res_idx;
        match_count <= res_cnt;
      end
    end
  end
endmodule

// File: tb/tb_sme_scan.sv
// Bench for sme_scan: directed and random patterns against a string-level reference model.
module tb_sme_scan;
  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int IDX_W   = 5;
  localparam int CNT_W   = 6;
  localparam int RW      = 1 + IDX_W + CNT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       chardata = '0;
  logic             isstring = 1'b0;
  logic             ispattern = 1'b0;
  logic             busy, valid, match;
  logic [IDX_W-1:0] match_index;
  logic [CNT_W-1:0] match_count;
  logic [2:0]       dbg_state;

  sme_scan #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .busy(busy), .valid(valid), .match(match),
    .match_index(match_index), .match_count(match_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]    m_str[$];
  logic [7:0]    m_pat[$];
  logic [RW-1:0] exp_q[$];
  int e_lat;
  int r_match, r_idx, r_cnt, r_lat, r_busy;

  // Reference: does pattern elements [lo,hi) match the model string starting at p?
  function automatic bit seq_ok(input int lo, input int hi, input int p, output int endp);
    int pos;
    int slen;
    pos = p;
    slen = m_str.size();
    endp = p;
    for (int k = lo; k < hi; k++) begin
      logic [7:0] c;
      c = m_pat[k];
      if (c == 8'h5E) begin
        if (pos != 0 && m_str[pos-1] != 8'h20) return 1'b0;
      end else if (c == 8'h24) begin
        if (pos != slen && m_str[pos] != 8'h20) return 1'b0;
      end else begin
        if (pos >= slen) return 1'b0;
        if (c != 8'h2E && c != m_str[pos]) return 1'b0;
        pos++;
      end
    end
    endp = pos;
    return 1'b1;
  endfunction

  // Expected result and valid latency (cycles after the pattern's terminating low cycle).
  function automatic void model_run();
    int slen, plen, star, e, j0, ia, ac, bc, em, ei, ec;
    bit ha, hb;
    slen = m_str.size();
    plen = m_pat.size();
    star = -1;
    em = 0; ei = 0; ec = 0;
    for (int k = 0; k < plen; k++) if (m_pat[k] == 8'h2A && star < 0) star = k;
    if (slen == 0) begin
      e_lat = 1;
    end else if (star < 0) begin
      for (int i = 0; i < slen; i++) begin
        if (seq_ok(0, plen, i, e)) begin
          if (ec == 0) ei = i;
          ec++;
        end
      end
      em = (ec > 0) ? 1 : 0;
      e_lat = slen + 1;
    end else begin
      ha = 1'b0; ac = 0; ia = 0; j0 = 0;
      if (star == 0) ha = 1'b1;
      else begin
        for (int i = 0; i < slen && !ha; i++) begin
          ac++;
          if (seq_ok(0, star, i, e)) begin
            ha = 1'b1; ia = i; j0 = e;
          end
        end
      end
      hb = 1'b0; bc = 0;
      if (ha) begin
        for (int j = j0; j <= slen && !hb; j++) begin
          bc++;
          if (seq_ok(star + 1, plen, j, e)) hb = 1'b1;
        end
      end
      em = hb ? 1 : 0;
      ei = hb ? ia : 0;
      ec = em;
      e_lat = ac + bc + 1;
    end
    exp_q.push_back({em[0], IDX_W'(ei), CNT_W'(ec)});
  endfunction

  task automatic send_string(input string s);
    m_str.delete();
    for (int i = 0; i < s.len(); i++) begin
      chardata = s[i];
      isstring = 1'b1;
      @(negedge clk);
      if (m_str.size() < STR_MAX) m_str.push_back(s[i]);
    end
    isstring = 1'b0;
  endtask

  // Sends a pattern, waits for valid, scores it, and returns at the cycle after valid.
  task automatic run_pattern(input string p, input bit hold, input bit poke);
    logic [RW-1:0] exp;
    int k;
    bit got;
    m_pat.delete();
    for (int i = 0; i < p.len(); i++) begin
      chardata = p[i];
      ispattern = 1'b1;
      @(negedge clk);
      if (m_pat.size() < PAT_MAX) m_pat.push_back(p[i]);
    end
    ispattern = 1'b0;
    chardata = '0;
    model_run();
    exp = exp_q.pop_front();
    k = 0; got = 1'b0; r_busy = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (busy) r_busy++;
      if (valid) got = 1'b1;
      if (poke && e_lat >= 3 && k == 1) begin
        ispattern = 1'b1;
        chardata = 8'h61;
      end else if (k == 2) begin
        ispattern = 1'b0;
      end
    end
    r_lat = k;
    r_match = match;
    r_idx = match_index;
    r_cnt = match_count;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no valid after %0d cycles, want valid at %0d", p, k, e_lat);
    end else begin
      checks++;
      if (match !== exp[RW-1]) begin
        errors++;
        $display("FAIL %s match got %0b want %0b", p, match, exp[RW-1]);
      end
      checks++;
      if (match_index !== exp[CNT_W +: IDX_W]) begin
        errors++;
        $display("FAIL %s index got %0d want %0d", p, match_index, exp[CNT_W +: IDX_W]);
      end
      checks++;
      if (match_count !== exp[CNT_W-1:0]) begin
        errors++;
        $display("FAIL %s count got %0d want %0d", p, match_count, exp[CNT_W-1:0]);
      end
      checks++;
      if (k != e_lat) begin
        errors++;
        $display("FAIL %s latency got %0d want %0d", p, k, e_lat);
      end
      checks++;
      if (r_busy != e_lat) begin
        errors++;
        $display("FAIL %s busy cycles got %0d want %0d", p, r_busy, e_lat);
      end
    end
    @(negedge clk);
    if (hold) begin
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL %s valid not a strobe: got %0b want 0", p, valid);
      end
      checks++;
      if ({match, match_index, match_count} !== exp) begin
        errors++;
        $display("FAIL %s hold got %h want %h", p, {match, match_index, match_count}, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({valid, match, match_index, match_count, busy} !== '0) begin
      errors++;
      $display("FAIL reset outputs got v=%0b m=%0b i=%0d c=%0d b=%0b want all 0",
               valid, match, match_index, match_count, busy);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send_string("hello world");
    run_pattern("o", 1'b1, 1'b0);
    checks++;
    if (r_match != 1 || r_idx != 4 || r_cnt != 2 || r_lat != 12) begin
      errors++;
      $display("FAIL basic_o got m=%0d i=%0d c=%0d lat=%0d want 1 4 2 12", r_match, r_idx, r_cnt, r_lat);
    end
  endtask

  task automatic test_anchors();
    run_pattern("^wor", 1'b1, 1'b0);
    checks++;
    if (r_match != 1 || r_idx != 6 || r_cnt != 1) begin
      errors++;
      $display("FAIL anchor_caret got m=%0d i=%0d c=%0d want 1 6 1", r_match, r_idx, r_cnt);
    end
    run_pattern("lo$", 1'b1, 1'b0);
    checks++;
    if (r_match != 1 || r_idx != 3 || r_cnt != 1) begin
      errors++;
      $display("FAIL anchor_dollar got m=%0d i=%0d c=%0d want 1 3 1", r_match, r_idx, r_cnt);
    end
    run_pattern("^lo", 1'b1, 1'b0);
    checks++;
    if (r_match != 0 || r_idx != 0 || r_cnt != 0) begin
      errors++;
      $display("FAIL anchor_miss got m=%0d i=%0d c=%0d want 0 0 0", r_match, r_idx, r_cnt);
    end
  endtask

  task automatic test_star();
    run_pattern("h*d", 1'b1, 1'b0);
    checks++;
    if (r_match != 1 || r_idx != 0 || r_cnt != 1 || r_lat > 25) begin
      errors++;
      $display("FAIL star_hd got m=%0d i=%0d c=%0d lat=%0d want 1 0 1 lat<=25", r_match, r_idx, r_cnt, r_lat);
    end
    run_pattern("w*h", 1'b1, 1'b0);
    checks++;
    if (r_match != 0 || r_idx != 0 || r_cnt != 0) begin
      errors++;
      $display("FAIL star_wh got m=%0d i=%0d c=%0d want 0 0 0", r_match, r_idx, r_cnt);
    end
    run_pattern("*ld$", 1'b1, 1'b0);
    checks++;
    if (r_match != 1 || r_idx != 0) begin
      errors++;
      $display("FAIL star_lead got m=%0d i=%0d want 1 0", r_match, r_idx);
    end
  endtask

  task automatic test_dot_count();
    send_string("abab");
    run_pattern("a.a", 1'b1, 1'b0);
    checks++;
    if (r_idx != 0 || r_cnt != 1) begin
      errors++;
      $display("FAIL dot_aa got i=%0d c=%0d want 0 1", r_idx, r_cnt);
    end
    run_pattern("b", 1'b1, 1'b0);
    checks++;
    if (r_idx != 1 || r_cnt != 2) begin
      errors++;
      $display("FAIL reuse_b got i=%0d c=%0d want 1 2", r_idx, r_cnt);
    end
  endtask

  task automatic test_truncation();
    string s;
    string alpha;
    alpha = "ab";
    s = "";
    for (int i = 0; i < 37; i++) s = $sformatf("%s%c", s, alpha[$urandom_range(0, 1)]);
    s = {s, "xyz"};
    send_string(s);
    run_pattern("xyz", 1'b1, 1'b0);
    // 32 scan cycles plus the valid cycle, all with busy high.
    checks++;
    if (r_match != 0 || r_lat != 33 || r_busy != 33) begin
      errors++;
      $display("FAIL truncation got m=%0d lat=%0d busy=%0d want 0 33 33", r_match, r_lat, r_busy);
    end
  endtask

  task automatic test_busy_ignore();
    send_string("hello world");
    run_pattern("l", 1'b1, 1'b1);
    checks++;
    if (r_match != 1 || r_idx != 2 || r_cnt != 3) begin
      errors++;
      $display("FAIL busy_poke got m=%0d i=%0d c=%0d want 1 2 3", r_match, r_idx, r_cnt);
    end
    run_pattern("o*r", 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    send_string("abcabc");
    run_pattern("c", 1'b0, 1'b0);
    run_pattern("bc", 1'b0, 1'b0);
    send_string("xx a");
    run_pattern("^a", 1'b1, 1'b0);
    checks++;
    if (r_match != 1 || r_idx != 3 || r_cnt != 1) begin
      errors++;
      $display("FAIL b2b_anchor got m=%0d i=%0d c=%0d want 1 3 1", r_match, r_idx, r_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    send_string("hello world");
    run_pattern("l", 1'b0, 1'b0);
    chardata = 8'h6F;
    ispattern = 1'b1;
    @(negedge clk);
    ispattern = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({valid, match, match_index, match_count, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs got v=%0b m=%0b i=%0d c=%0d b=%0b want all 0",
               valid, match, match_index, match_count, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    m_str.delete();
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid stray valid got %0d want 0", seen);
    end
    run_pattern("a", 1'b1, 1'b0);
    checks++;
    if (r_match != 0 || r_lat != 1) begin
      errors++;
      $display("FAIL empty_string got m=%0d lat=%0d want 0 1", r_match, r_lat);
    end
  endtask

  function automatic bit legal_pat(input string p);
    int star;
    star = -1;
    for (int i = 0; i < p.len() && i < PAT_MAX; i++) begin
      if (p[i] == 8'h2A && star < 0) star = i;
      else if (p[i] != 8'h5E && p[i] != 8'h24) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic test_random();
    string s, p, salpha, palpha;
    int n, pos;
    salpha = "ab ";
    palpha = "ab.^$ ";
    for (int g = 0; g < 6; g++) begin
      s = "";
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) s = $sformatf("%s%c", s, salpha[$urandom_range(0, 2)]);
      send_string(s);
      for (int t = 0; t < 4; t++) begin
        p = "";
        for (int tries = 0; tries < 50 && !legal_pat(p); tries++) begin
          p = "";
          n = $urandom_range(1, 5);
          pos = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n) : -1;
          for (int i = 0; i <= n; i++) begin
            if (i == pos) p = {p, "*"};
            if (i < n) p = $sformatf("%s%c", p, palpha[$urandom_range(0, 5)]);
          end
        end
        if (!legal_pat(p)) p = "a";
        run_pattern(p, 1'b1, ($urandom_range(0, 1) == 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_anchors();
    test_star();
    test_dot_count();
    test_truncation();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sme_scan.md
# sme_scan

Parametrised sequential string-matching engine, the next generation of the team's SME block. It stores one string of up to STR_MAX characters and evaluates one or more patterns against it. Patterns may use the metacharacters '^', '$', '.' and a single '*'. Instead of a flat parallel compare, it scans one candidate position per cycle, which keeps area linear in PAT_MAX. It reports first-match position and, for star-free patterns, the total occurrence count.

## Interface
- STR_MAX, 32, maximum stored string length (characters)
- PAT_MAX, 8, maximum pattern length including metacharacters
- IDX_W, 5, width of match_index; must satisfy 2^IDX_W >= STR_MAX
- CNT_W, 6, width of match_count; must satisfy 2^CNT_W > STR_MAX
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- chardata  in  8  ASCII character, sampled when isstring or ispattern is high
- isstring  in  1  chardata is a string character (contiguous burst)
- ispattern  in  1  chardata is a pattern character (contiguous burst)
- busy  out  1  high from the first cycle after pattern end until valid is high, inclusive
- valid  out  1  one-cycle result strobe
- match  out  1  pattern found
- match_index  out  IDX_W  start position of first match, 0-based; 0 when match=0
- match_count  out  CNT_W  number of matches, see Operation

## Operation
- **FSM states:** IDLE, LOAD_STR, LOAD_PAT, SCAN, SCAN_A, SCAN_B, DONE.
- **IDLE:**
  - isstring goes to LOAD_STR and clears the stored string (L=0).
  - ispattern goes to LOAD_PAT and keeps the previous string.
- **LOAD_STR:**
  - Each isstring cycle stores chardata at S[L] and increments L.
  - Once L=STR_MAX, further characters are dropped and L saturates.
  - ispattern goes to LOAD_PAT.
- **LOAD_PAT:**
  - Each ispattern cycle stores P[M] and increments M.
  - Characters beyond PAT_MAX are dropped.
  - The first '*' records star position K.
  - Any later '*' is compared as a literal 0x2A.
  - The first cycle with ispattern low ends the pattern. Go to SCAN if there is no star, otherwise SCAN_A.
- **Element semantics:**
  - '.' matches any single character.
  - '^' is zero-width; true at position p if p=0 or S[p-1]=0x20.
  - '$' is zero-width; true at p if p=L or S[p]=0x20.
  - A literal matches an equal byte.
  - A window that runs past L fails, except for trailing zero-width '$' at p=L.
  - A pattern must contain at least one non-anchor character outside the star; other patterns are illegal input.
- **Match position:** the string index of the first consumed character.
- **SCAN (no star):**
  - Evaluates candidate start i = 0..L-1, one per cycle, always L cycles.
  - match_count = number of i that match.
  - match_index = smallest matching i.
- **SCAN_A (star; A = P[0..K-1], B = P[K+1..M-1]):**
  - Finds the leftmost start i of A and stops on the first hit.
  - A empty: i=0, 0 cycles.
  - No hit: go to DONE with match=0.
- **SCAN_B:**
  - Searches start j from i+consumed_len(A) to L and stops on the first hit.
  - B empty: immediate hit.
  - match=1 with match_index=i, otherwise match=0.
  - Star result: match_count = match ? 1 : 0.
- **DONE:**
  - Drives valid=1 for one cycle and updates match, match_index and match_count.
  - Returns to IDLE; the stored string is retained for the next pattern.
- **Ignored input:** isstring or ispattern while busy is ignored.
- **Empty string:** ispattern with L=0 (no string since reset) yields match=0.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; L=0, M=0.
- **Reset mid-scan:** aborts immediately; no valid is produced for that pattern.
- **Latency, no star:** let T be the first cycle with ispattern low. SCAN occupies T+1..T+L and valid is high at T+L+1.
- **Latency, star:** valid is at most 2L+3 cycles after T, and exactly one cycle after the terminating SCAN_A or SCAN_B cycle.
- **Output hold:** match, match_index and match_count hold their values until the next valid.
- **Back-to-back input:** isstring or ispattern may start in the cycle after valid.
- **Counter widths:** counters saturate and never wrap. L max = STR_MAX and match_count max = STR_MAX, both fitting the declared widths.

## Test plan
- **Basic count:** string "hello world" (L=11), pattern "o" -> match=1, index=4, count=2, valid at T+12.
- **Anchors, same string:**
  - "^wor" -> match=1, index=6, count=1.
  - "lo$" -> match=1, index=3, count=1.
  - "^lo" -> match=0, index=0, count=0.
- **Star, same string:**
  - "h*d" -> match=1, index=0, count=1.
  - "w*h" -> match=0, index=0, count=0.
  - "*ld$" -> match=1, index=0.
- **Dot and count:** string "abab", pattern "a.a" -> index=0, count=1. Pattern "b" -> index=1, count=2, string reused with no reload.
- **Truncation:** with STR_MAX=32, send a 40-character string ending in "xyz", then pattern "xyz" -> match=0. Check that L stops at 32 and busy pulses for 32 scan cycles.
- **Reset and busy:**
  - Assert reset low during SCAN -> all outputs 0, no valid.
  - Then send pattern "a" with no string -> valid with match=0.
  - ispattern pulsed while busy -> no effect on the result.
